vga_sram_arbiter: RTL
=====================

Name: vga_sram_arbiter

Overview:
Shares one asynchronous 16-bit SRAM between two requesters:
- Display read port (VGA scan-out), which has priority.
- Write port (the pattern generator or a later framebuffer writer).

The block sequences SRAM control strobes for single-word reads and writes and returns read data with fixed latency. It sits between the requesters and the top-level SRAM pins.

Parameters:
ADDR_BITS, 20, SRAM address width
DATA_BITS, 16, SRAM data width
STARVE_LIMIT, 8, consecutive lost-arbitration cycles before the write port is forced through (used only with the optional feature)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
rd_req  input  1  display read request
rd_addr  input  ADDR_BITS  read address, sampled on grant
rd_ready  output  1  read grant this cycle (combinational)
rd_data  output  DATA_BITS  read data
rd_data_valid  output  1  one-cycle pulse, rd_data valid
wr_req  input  1  write request
wr_addr  input  ADDR_BITS  write address, sampled on grant
wr_data  input  DATA_BITS  write data, sampled on grant
wr_ready  output  1  write grant this cycle (combinational)
sram_addr  output  ADDR_BITS  SRAM address
sram_data_out  output  DATA_BITS  data to pad driver
sram_data_oe  output  1  pad driver enable
sram_data_in  input  DATA_BITS  data from pad
sram_ce_n  output  1  chip enable, active low
sram_oe_n  output  1  output enable, active low
sram_we_n  output  1  write enable, active low

Behaviour:
- Reset is asynchronous on the negedge of reset_n. While reset_n is low:
  - state=IDLE, sram_addr=0, sram_data_out=0, sram_data_oe=0.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1.
  - rd_data=0, rd_data_valid=0, starve counter=0.
  - rd_ready=0, wr_ready=0.
- Reset mid-write deasserts sram_we_n immediately. The aborted word is undefined.
- All strobes are registered; there are no glitching combinational SRAM outputs.
- States: IDLE, READ, W_SETUP, W_PULSE, W_HOLD.
- Grant happens only in IDLE:
  - rd_ready = IDLE && rd_req.
  - wr_ready = IDLE && wr_req && !rd_req.
  - A grant is a handshake (req && ready). Requesters may hold req high across cycles.
- Read transaction:
  - Grant cycle N: latch rd_addr into sram_addr; go to READ.
  - Cycle N+1 (READ): ce_n=0, oe_n=0. Sample sram_data_in into rd_data at the end of the cycle. Go to IDLE.
  - Cycle N+2: rd_data_valid=1 for exactly one cycle.
  - Throughput: one read per 2 cycles.
- Write transaction:
  - Grant cycle N: latch wr_addr and wr_data; go to W_SETUP.
  - W_SETUP (N+1): ce_n=0, data_oe=1, we_n=1.
  - W_PULSE (N+2): we_n=0.
  - W_HOLD (N+3): we_n=1, data_oe=1, address and data still held.
  - Return to IDLE; next grant is possible at N+4.
- oe_n is never low while data_oe=1. The IDLE cycle between transactions is the bus turnaround.
- In IDLE, ce_n=1, oe_n=1, we_n=1, data_oe=0. sram_addr holds its last value.
- Simultaneous rd_req and wr_req in IDLE: read wins.
- Requests arriving in a non-IDLE state are not lost. They wait while req stays high.

Optional Feature:
VGA_SRAM_ARB_STARVE_GUARD_EN
- With the macro defined:
  - A counter increments each IDLE cycle in which wr_req=1 and the read port wins. It saturates at STARVE_LIMIT.
  - When the counter equals STARVE_LIMIT in IDLE, the write port wins: wr_ready=1, rd_ready=0.
  - The counter clears on any write grant.
- Without the macro: strict read priority, and no counter logic is synthesized.

Decomposition:
- Shared header vga_sram_defs.v holds:
  - State encoding localparams (3-bit).
  - SRAM timing constants (write-pulse cycles = 1).
  - Default ADDR_BITS and DATA_BITS.
- One natural sub-module: vga_sram_arb_pick. It contains the combinational grant logic plus the optional starve counter, and is reused by future multi-port SRAM controllers.
- The FSM and strobe registers stay in vga_sram_arbiter.

Test Plan:
- Reset: pull reset_n low mid-W_PULSE -> sram_we_n=1 and sram_ce_n=1 immediately (before the next clk edge); rd_data_valid=0; state returns to IDLE.
- Single read: rd_req with rd_addr=0x00280 granted at cycle N, SRAM model returns 0xF0F0 -> sram_addr=0x00280 with oe_n=0 at N+1; rd_data=0xF0F0 with rd_data_valid=1 at N+2 only.
- Single write: wr_addr=0x12C00, wr_data=0x0F00 granted at N -> we_n=0 only at N+2; data_oe=1 during N+1..N+3; SRAM model holds 0x0F00 at 0x12C00; wr_ready high again at N+4 if wr_req held.
- Contention: rd_req and wr_req both high in IDLE -> rd_ready=1, wr_ready=0; the write is granted in the first IDLE with rd_req low; oe_n and data_oe never both active (assertion).
- Streaming reads: rd_req held high for 640 addresses -> 640 rd_data_valid pulses, exactly 2 cycles apart, data matching the model in order.
- Guard (macro on, STARVE_LIMIT=8): rd_req held high continuously while wr_req=1 -> write granted after 8 lost IDLE arbitrations; without the macro the write is never granted.

Source files
------------

// File: rtl/vga_sram_arbiter_pkg.sv
// Shared definitions for the VGA SRAM arbiter: state encoding, default widths, strobe bundle.
// The write-starvation guard is enabled by defining VGA_SRAM_ARB_STARVE_GUARD_EN.
package vga_sram_arbiter_pkg;

  localparam int unsigned ADDR_BITS_DEF    = 20;
  localparam int unsigned DATA_BITS_DEF    = 16;
  localparam int unsigned STARVE_LIMIT_DEF = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_READ    = 3'd1;
  localparam logic [2:0] ST_W_SETUP = 3'd2;
  localparam logic [2:0] ST_W_PULSE = 3'd3;
  localparam logic [2:0] ST_W_HOLD  = 3'd4;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic data_oe;
  } sram_ctl_t;

  localparam sram_ctl_t CTL_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, data_oe: 1'b0};

  // SRAM strobes to present while the FSM sits in state st.
  function automatic sram_ctl_t ctl_for_state(input logic [2:0] st);
    sram_ctl_t c;
    c = CTL_IDLE;
    case (st)
      ST_READ: begin
        c.ce_n = 1'b0;
        c.oe_n = 1'b0;
      end
      ST_W_SETUP, ST_W_HOLD: begin
        c.ce_n    = 1'b0;
        c.data_oe = 1'b1;
      end
      ST_W_PULSE: begin
        c.ce_n    = 1'b0;
        c.data_oe = 1'b1;
        c.we_n    = 1'b0;
      end
      default: c = CTL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_sram_arb_pick.sv
// Two-port grant logic (read priority) with optional write-starvation counter.
// Counter and forced write grant exist only when VGA_SRAM_ARB_STARVE_GUARD_EN is defined.
module vga_sram_arb_pick
  import vga_sram_arbiter_pkg::*;
`ifdef VGA_SRAM_ARB_STARVE_GUARD_EN
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
)
`endif
(
`ifdef VGA_SRAM_ARB_STARVE_GUARD_EN
  input  logic clk,
  input  logic reset_n,
`endif
  input  logic i_idle,
  input  logic i_rd_req,
  input  logic i_wr_req,
  output logic o_rd_grant,
  output logic o_wr_grant
);

  logic w_force;

`ifdef VGA_SRAM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_BITS = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(STARVE_LIMIT);

  logic [CNT_BITS-1:0] r_starve_cnt;

  assign w_force = i_wr_req && (r_starve_cnt == CNT_MAX);

  // Counts IDLE cycles in which a pending write lost to a read; saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (o_wr_grant) begin
      r_starve_cnt <= '0;
    end else if (i_idle && i_wr_req && o_rd_grant && (r_starve_cnt != CNT_MAX)) begin
      r_starve_cnt <= r_starve_cnt + CNT_BITS'(1);
    end
  end
`else
  assign w_force = 1'b0;
`endif

  assign o_rd_grant = i_idle && i_rd_req && !w_force;
  assign o_wr_grant = i_idle && i_wr_req && (!i_rd_req || w_force);

endmodule

// File: rtl/vga_sram_arbiter.sv
// Arbitrates a display read port and a write port onto one asynchronous SRAM with registered strobes.
// Define VGA_SRAM_ARB_STARVE_GUARD_EN to force a starved write through after STARVE_LIMIT lost cycles.
module vga_sram_arbiter
  import vga_sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BITS = ADDR_BITS_DEF,
  parameter int unsigned DATA_BITS = DATA_BITS_DEF
`ifdef VGA_SRAM_ARB_STARVE_GUARD_EN
  ,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rd_req,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_ready,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_data_valid,
  input  logic                 wr_req,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_ready,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [DATA_BITS-1:0] sram_data_out,
  output logic                 sram_data_oe,
  input  logic [DATA_BITS-1:0] sram_data_in,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);

  logic [2:0]           r_state;
  logic [2:0]           w_state_next;
  sram_ctl_t            r_ctl;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_wdata;
  logic [DATA_BITS-1:0] r_rdata;
  logic                 r_rvalid;
  logic                 w_idle;
  logic                 w_rd_grant;
  logic                 w_wr_grant;

  // Grants are suppressed while reset is held, not just on the next edge.
  assign w_idle = reset_n && (r_state == ST_IDLE);

  vga_sram_arb_pick
`ifdef VGA_SRAM_ARB_STARVE_GUARD_EN
  #(
    .STARVE_LIMIT (STARVE_LIMIT)
  )
`endif
  u_pick (
`ifdef VGA_SRAM_ARB_STARVE_GUARD_EN
    .clk        (clk),
    .reset_n    (reset_n),
`endif
    .i_idle     (w_idle),
    .i_rd_req   (rd_req),
    .i_wr_req   (wr_req),
    .o_rd_grant (w_rd_grant),
    .o_wr_grant (w_wr_grant)
  );

  assign rd_ready = w_rd_grant;
  assign wr_ready = w_wr_grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_grant) begin
          w_state_next = ST_READ;
        end else if (w_wr_grant) begin
          w_state_next = ST_W_SETUP;
        end
      end
      ST_READ:    w_state_next = ST_IDLE;
      ST_W_SETUP: w_state_next = ST_W_PULSE;
      ST_W_PULSE: w_state_next = ST_W_HOLD;
      ST_W_HOLD:  w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they change only on clock edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctl    <= CTL_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_ctl    <= ctl_for_state(w_state_next);
      r_rvalid <= (r_state == ST_READ);
      if (w_rd_grant) begin
        r_addr <= rd_addr;
      end else if (w_wr_grant) begin
        r_addr  <= wr_addr;
        r_wdata <= wr_data;
      end
      if (r_state == ST_READ) begin
        r_rdata <= sram_data_in;
      end
    end
  end

  assign sram_addr     = r_addr;
  assign sram_data_out = r_wdata;
  assign sram_data_oe  = r_ctl.data_oe;
  assign sram_ce_n     = r_ctl.ce_n;
  assign sram_oe_n     = r_ctl.oe_n;
  assign sram_we_n     = r_ctl.we_n;
  assign rd_data       = r_rdata;
  assign rd_data_valid = r_rvalid;

endmodule
